current_setpoint_ramp: RTL and testbench

Registered, parametrised current-setpoint generator. It decodes a current code into a target current in I-units and a display value in I_deco-units, like the current lookup table. Unlike that table, the output current moves toward each new target in slew-limited steps on a programmable tick instead of jumping. It sits between the user/keypad code path and the current controller and display decoder.

---
 rtl/current_setpoint_ramp.sv | 110 +++++++++++
 tb/tb_current_setpoint_ramp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/current_setpoint_ramp.sv
// Slew-limited current setpoint generator: decodes a current code into a target and ramps I toward it
// in bounded steps on a programmable tick. Optional sticky out-of-range flag under `RANGE_ERR_EN`.
module current_setpoint_ramp #(
  parameter int unsigned CODE_W     = 4,
  parameter int unsigned MAX_CODE   = 10,
  parameter int unsigned UNIT       = 10,
  parameter int unsigned DECO_SCALE = 10,
  parameter int unsigned I_W        = 7,
  parameter int unsigned DECO_W     = 10,
  parameter int unsigned STEP       = 10,
  parameter int unsigned TICK_DIV   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] corriente,
  input  logic              load,
  output logic [I_W-1:0]    I,
  output logic [DECO_W-1:0] I_deco,
  output logic [I_W-1:0]    target,
  output logic              ramping,
  output logic              done
`ifdef RANGE_ERR_EN
  ,
  output logic              range_err
`endif
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {IDLE, RAMP} state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic             code_bad;
  logic             tick_last;
  logic [I_W-1:0]   new_target;
  logic [I_W-1:0]   eff_target;
  logic [I_W-1:0]   diff;
  logic [I_W-1:0]   step_amt;
  logic [I_W-1:0]   next_i;

  // A load coincident with a terminal tick steps toward the freshly decoded target.
  always_comb begin
    code_bad   = 32'(corriente) > MAX_CODE;
    new_target = code_bad ? '0 : I_W'(32'(corriente) * UNIT);
    eff_target = load ? new_target : target;
    diff       = (eff_target > I) ? (eff_target - I) : (I - eff_target);
    step_amt   = (32'(diff) > STEP) ? I_W'(STEP) : diff;
    next_i     = (eff_target > I) ? (I + step_amt) : (I - step_amt);
    tick_last  = (tick_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      I        <= '0;
      I_deco   <= '0;
      target   <= '0;
      ramping  <= 1'b0;
      done     <= 1'b0;
`ifdef RANGE_ERR_EN
      range_err <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef RANGE_ERR_EN
      if (load && code_bad) range_err <= 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (load) begin
            target <= new_target;
            if (new_target == I) begin
              done <= 1'b1;
            end else begin
              tick_cnt <= '0;
              state    <= RAMP;
              ramping  <= 1'b1;
            end
          end
        end
        RAMP: begin
          if (load) target <= new_target;
          // Retarget onto the present I finishes at once; otherwise the tick cadence is kept.
          if (load && (new_target == I)) begin
            state    <= IDLE;
            ramping  <= 1'b0;
            done     <= 1'b1;
            tick_cnt <= '0;
          end else if (tick_last) begin
            I        <= next_i;
            I_deco   <= DECO_W'(32'(next_i) * DECO_SCALE);
            tick_cnt <= '0;
            if (next_i == eff_target) begin
              state   <= IDLE;
              ramping <= 1'b0;
              done    <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_current_setpoint_ramp.sv
// Directed bench for current_setpoint_ramp: per-cycle vector table on a STEP=10 instance plus
// hand-written sequences for clamped STEP=25 ramping and asynchronous reset mid-ramp.
module tb_current_setpoint_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_a, code_b;
  logic       load_a, load_b;
  logic [6:0] i_a, i_b, tgt_a, tgt_b;
  logic [9:0] deco_a, deco_b;
  logic       rmp_a, rmp_b, dn_a, dn_b;
`ifdef RANGE_ERR_EN
  logic       re_a, re_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  current_setpoint_ramp #(.TICK_DIV(4), .STEP(10)) dut_a (
    .clk(clk), .rst(rst), .corriente(code_a), .load(load_a),
    .I(i_a), .I_deco(deco_a), .target(tgt_a), .ramping(rmp_a), .done(dn_a)
`ifdef RANGE_ERR_EN
    , .range_err(re_a)
`endif
  );

  current_setpoint_ramp #(.TICK_DIV(4), .STEP(25)) dut_b (
    .clk(clk), .rst(rst), .corriente(code_b), .load(load_b),
    .I(i_b), .I_deco(deco_b), .target(tgt_b), .ramping(rmp_b), .done(dn_b)
`ifdef RANGE_ERR_EN
    , .range_err(re_b)
`endif
  );

  typedef struct {
    logic       ld;
    logic [3:0] code;
    int         i;
    int         tgt;
    logic       rmp;
    logic       dn;
    logic       re;
  } vec_t;

  vec_t vec[$];
  logic re_exp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input logic ld, input int code, input int i, input int tgt,
                              input logic rmp, input logic dn);
    vec_t v;
    v.ld = ld; v.code = 4'(code); v.i = i; v.tgt = tgt;
    v.rmp = rmp; v.dn = dn; v.re = re_exp;
    vec.push_back(v);
  endfunction

  // Three idle-tick cycles at prev followed by the step edge landing on nxt.
  function automatic void tick(input int prev, input int nxt, input int tgt, input logic last);
    for (int k = 0; k < 3; k++) add(1'b0, 0, prev, tgt, 1'b1, 1'b0);
    add(1'b0, 0, nxt, tgt, !last, last);
  endfunction

  initial begin
    int dn_cnt;
    int exp_i;

    // Ramp 0 -> 30
    add(1, 3, 0, 30, 1, 0);
    tick(0, 10, 30, 0); tick(10, 20, 30, 0); tick(20, 30, 30, 1);
    add(0, 0, 30, 30, 0, 0);
    // Load equal to I in IDLE
    add(1, 3, 30, 30, 0, 1);
    add(0, 0, 30, 30, 0, 0);
    // Mid-ramp reversal, cadence kept
    add(1, 10, 30, 100, 1, 0);
    tick(30, 40, 100, 0);
    add(1, 2, 40, 20, 1, 0);
    add(0, 0, 40, 20, 1, 0); add(0, 0, 40, 20, 1, 0);
    add(0, 0, 30, 20, 1, 0);
    tick(30, 20, 20, 1);
    add(0, 0, 20, 20, 0, 0);
    // Load coincident with terminal tick steps toward the new target
    add(1, 5, 20, 50, 1, 0);
    tick(20, 30, 50, 0);
    for (int k = 0; k < 3; k++) add(0, 0, 30, 50, 1, 0);
    add(1, 0, 20, 0, 1, 0);
    tick(20, 10, 0, 0); tick(10, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    // Up to 50, then out-of-range code forces target 0
    add(1, 5, 0, 50, 1, 0);
    tick(0, 10, 50, 0); tick(10, 20, 50, 0); tick(20, 30, 50, 0);
    tick(30, 40, 50, 0); tick(40, 50, 50, 1);
    re_exp = 1'b1;
    add(1, 13, 50, 0, 1, 0);
    tick(50, 40, 0, 0);
    // Retarget onto present I during RAMP
    add(1, 4, 40, 40, 0, 1);
    add(0, 0, 40, 40, 0, 0);
    add(1, 11, 40, 0, 1, 0);
    tick(40, 30, 0, 0); tick(30, 20, 0, 0); tick(20, 10, 0, 0); tick(10, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);
    add(1, 15, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0);

    rst = 1'b1; load_a = 1'b0; load_b = 1'b0; code_a = '0; code_b = '0;
    repeat (2) @(negedge clk);
    check("reset I", 32'(i_a), 0);
    check("reset I_deco", 32'(deco_a), 0);
    check("reset target", 32'(tgt_a), 0);
    check("reset ramping", 32'(rmp_a), 0);
    check("reset done", 32'(dn_a), 0);
    rst = 1'b0;

    for (int k = 0; k < vec.size(); k++) begin
      @(negedge clk);
      load_a = vec[k].ld;
      code_a = vec[k].code;
      @(posedge clk);
      #1;
      check($sformatf("row%0d I", k), 32'(i_a), 32'(vec[k].i));
      check($sformatf("row%0d I_deco", k), 32'(deco_a), 32'(vec[k].i * 10));
      check($sformatf("row%0d target", k), 32'(tgt_a), 32'(vec[k].tgt));
      check($sformatf("row%0d ramping", k), 32'(rmp_a), 32'(vec[k].rmp));
      check($sformatf("row%0d done", k), 32'(dn_a), 32'(vec[k].dn));
`ifdef RANGE_ERR_EN
      check($sformatf("row%0d range_err", k), 32'(re_a), 32'(vec[k].re));
`endif
    end
    @(negedge clk);
    load_a = 1'b0;

    // STEP=25: 0 -> 30 with clamped second step
    code_b = 4'd3; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 4) check("b up25 I", 32'(i_b), 25);
      if (k == 8) begin
        check("b up30 I", 32'(i_b), 30);
        check("b up30 done", 32'(dn_b), 1);
      end
    end
    // STEP=25: 30 -> 100 as 55, 80, 100
    @(negedge clk);
    code_b = 4'd10; load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
    check("b load target", 32'(tgt_b), 100);
    check("b load ramping", 32'(rmp_b), 1);
    dn_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      exp_i = (k < 4) ? 30 : (k < 8) ? 55 : (k < 12) ? 80 : 100;
      check($sformatf("b cyc%0d I", k), 32'(i_b), 32'(exp_i));
      if (dn_b) dn_cnt++;
    end
    check("b final I_deco", 32'(deco_b), 1000);
    check("b final done", 32'(dn_b), 1);
    check("b final ramping", 32'(rmp_b), 0);
    check("b done pulses", 32'(dn_cnt), 1);
    @(posedge clk); #1;
    check("b done drops", 32'(dn_b), 0);

    // Asynchronous reset mid-ramp
    @(negedge clk);
    code_a = 4'd10; load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre-rst I", 32'(i_a), 10);
    #1;
    rst = 1'b1;
    #1;
    check("async rst I", 32'(i_a), 0);
    check("async rst I_deco", 32'(deco_a), 0);
    check("async rst target", 32'(tgt_a), 0);
    check("async rst ramping", 32'(rmp_a), 0);
    check("async rst done", 32'(dn_a), 0);
    check("async rst b I", 32'(i_b), 0);
    check("async rst b I_deco", 32'(deco_b), 0);
`ifdef RANGE_ERR_EN
    check("async rst range_err", 32'(re_a), 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("post-rst idle I", 32'(i_a), 0);
    check("post-rst idle ramping", 32'(rmp_a), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
